// File: rtl/draw_arbiter.sv
// draw_arbiter: round-robin plot arbiter with per-frame background-clear priority.
// Optional job watchdog is built only when DRAW_ARB_TIMEOUT_EN is defined.
module draw_arbiter #(
    parameter int unsigned TIMEOUT_CYC = 40000
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [3:0] req,
    input  logic       frame_tick,
    input  logic       plot_done,
    output logic [3:0] grant,
    output logic       plot_start,
    output logic [1:0] owner,
    output logic       busy,
    output logic       frame_pend,
    output logic       err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] owner_q, owner_d;
    logic       pend_q, pend_d;
    logic       sel_vld;
    logic [1:0] sel_idx;
    logic [1:0] rr_idx;
    logic       timeout;

    // Round-robin search from owner_q+1; owner_q doubles as last owner.
    always_comb begin
        sel_vld = 1'b0;
        sel_idx = 2'd0;
        rr_idx  = 2'd0;
        for (int k = 4; k >= 1; k--) begin
            rr_idx = owner_q + k[1:0];
            if (req[rr_idx]) begin
                sel_vld = 1'b1;
                sel_idx = rr_idx;
            end
        end
    end

    // Next-state: arbitrate in IDLE, one-cycle START, hold in WAIT.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        pend_d  = pend_q | frame_tick;
        unique case (state_q)
            IDLE: begin
                if (pend_q) begin
                    state_d = START;
                    owner_d = 2'd0;
                end else if (sel_vld) begin
                    state_d = START;
                    owner_d = sel_idx;
                end
            end
            START: state_d = WAIT;
            WAIT: begin
                if (plot_done || timeout) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (state_q == IDLE && state_d == START && owner_d == 2'd0) begin
            pend_d = frame_tick;
        end
    end

    // State, owner and frame-pending registers.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
            owner_q <= 2'd3;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            pend_q  <= pend_d;
        end
    end

    assign busy       = (state_q != IDLE);
    assign plot_start = (state_q == START);
    assign owner      = busy ? owner_q : 2'd0;
    assign grant      = busy ? (4'd1 << owner_q) : 4'd0;
    assign frame_pend = pend_q;

`ifdef DRAW_ARB_TIMEOUT_EN
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYC - 1);

    logic [15:0] cnt_q, cnt_d;
    logic        err_q, err_d;

    // Watchdog: cleared in START, counts WAIT cycles; plot_done wins a tie.
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == START) begin
            cnt_d = 16'd0;
        end else if (state_q == WAIT) begin
            cnt_d = cnt_q + 16'd1;
        end
        err_d = err_q | (timeout & ~plot_done);
    end

    assign timeout = (state_q == WAIT) && (cnt_q == TMO_LAST);

    // Watchdog counter and sticky error flag.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt_q <= 16'd0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign timeout = 1'b0;
    assign err     = 1'b0;
`endif

endmodule

// File: tb/tb_draw_arbiter.sv
// tb_draw_arbiter: job-level reference model compared every cycle,
// directed scenarios with literal grant expectations, then random traffic.
module tb_draw_arbiter;

    localparam int TMO = 50;

    logic       clk = 1'b0;
    logic       resetn;
    logic [3:0] req;
    logic       frame_tick;
    logic       plot_done;
    logic [3:0] grant;
    logic       plot_start;
    logic [1:0] owner;
    logic       busy;
    logic       frame_pend;
    logic       err;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: a job is active from its start cycle (age 0) on.
    bit m_act  = 0;
    int m_age  = 0;
    int m_own  = 0;
    int m_last = 3;
    bit m_pend = 0;
    bit m_err  = 0;

    always #5 clk = ~clk;

    draw_arbiter #(.TIMEOUT_CYC(TMO)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .req        (req),
        .frame_tick (frame_tick),
        .plot_done  (plot_done),
        .grant      (grant),
        .plot_start (plot_start),
        .owner      (owner),
        .busy       (busy),
        .frame_pend (frame_pend),
        .err        (err)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic void model_step();
        bit pend_in;
        int sel;
        int c;
        if (!resetn) begin
            m_act  = 0;
            m_age  = 0;
            m_own  = 0;
            m_last = 3;
            m_pend = 0;
            m_err  = 0;
            return;
        end
        pend_in = m_pend;
        m_pend  = m_pend | frame_tick;
        if (m_act) begin
            if (m_age > 0 && plot_done) begin
                m_act = 0;
            end
`ifdef DRAW_ARB_TIMEOUT_EN
            else if (m_age == TMO) begin
                m_act = 0;
                m_err = 1;
            end
`endif
            else begin
                m_age++;
            end
        end else begin
            sel = -1;
            if (pend_in) begin
                sel = 0;
            end else begin
                for (int k = 1; k <= 4; k++) begin
                    c = (m_last + k) % 4;
                    if (sel < 0 && req[c]) sel = c;
                end
            end
            if (sel >= 0) begin
                m_act  = 1;
                m_age  = 0;
                m_own  = sel;
                m_last = sel;
                if (sel == 0) m_pend = frame_tick;
            end
        end
    endfunction

    task automatic compare();
        logic [3:0] eg;
        eg = m_act ? 4'(1 << m_own) : 4'd0;
        chk("grant", 32'(grant), 32'(eg));
        chk("plot_start", 32'(plot_start), 32'(m_act && m_age == 0));
        chk("busy", 32'(busy), 32'(m_act));
        chk("owner", 32'(owner), m_act ? 32'(m_own) : 32'd0);
        chk("frame_pend", 32'(frame_pend), 32'(m_pend));
        chk("err", 32'(err), 32'(m_err));
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare();
    endtask

    task automatic wait_start(input string nm, input logic [3:0] exp);
        int n = 0;
        while (!plot_start && n < 20) begin
            cyc();
            n++;
        end
        chk({nm, "_seen"}, 32'(plot_start), 32'd1);
        chk(nm, 32'(grant), 32'(exp));
    endtask

    task automatic run_job(input string nm, input logic [3:0] exp,
                           input logic exp_fp, input int dly,
                           input int tick_at);
        wait_start(nm, exp);
        chk({nm, "_fp"}, 32'(frame_pend), 32'(exp_fp));
        for (int k = 0; k <= dly; k++) begin
            if (k == tick_at) frame_tick = 1'b1;
            if (k == dly) plot_done = 1'b1;
            cyc();
            frame_tick = 1'b0;
            plot_done  = 1'b0;
            if (k == 0) chk({nm, "_width"}, 32'(plot_start), 32'd0);
        end
        chk({nm, "_busy_drop"}, 32'(busy), 32'd0);
    endtask

    initial begin
        resetn     = 1'b0;
        req        = 4'b0000;
        frame_tick = 1'b0;
        plot_done  = 1'b0;
        cyc();
        cyc();
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_pend", 32'(frame_pend), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        resetn = 1'b1;
        repeat (3) cyc();
        chk("idle_quiet", 32'(busy), 32'd0);

        req = 4'b0110;
        run_job("rr1", 4'b0010, 1'b0, 10, -1);
        run_job("rr2", 4'b0100, 1'b0, 10, -1);
        run_job("rr3", 4'b0010, 1'b0, 10, -1);

        req = 4'b1110;
        run_job("ft1", 4'b0100, 1'b0, 4, -1);
        run_job("ft2", 4'b1000, 1'b0, 4, -1);
        run_job("ft_wall", 4'b0010, 1'b0, 6, 2);
        chk("ft_pend", 32'(frame_pend), 32'd1);
        run_job("ft_bg", 4'b0001, 1'b0, 4, -1);

        req = 4'b0100;
        run_job("co_bird", 4'b0100, 1'b0, 5, 5);
        chk("co_pend", 32'(frame_pend), 32'd1);
        run_job("co_bg", 4'b0001, 1'b0, 3, -1);
        run_job("co_bird2", 4'b0100, 1'b0, 3, -1);

        req = 4'b1111;
        wait_start("mr_job", 4'b1000);
        repeat (3) cyc();
        resetn = 1'b0;
        cyc();
        resetn = 1'b1;
        chk("mr_grant", 32'(grant), 32'd0);
        chk("mr_busy", 32'(busy), 32'd0);
        run_job("mr_next", 4'b0001, 1'b0, 3, -1);

        req = 4'b0110;
`ifdef DRAW_ARB_TIMEOUT_EN
        wait_start("wd_job", 4'b0010);
        repeat (TMO) cyc();
        chk("wd_hold", 32'(busy), 32'd1);
        cyc();
        chk("wd_grant", 32'(grant), 32'd0);
        chk("wd_err", 32'(err), 32'd1);
        wait_start("wd_next", 4'b0100);
`else
        wait_start("hold_job", 4'b0010);
        repeat (1000) cyc();
        chk("hold_grant", 32'(grant), 32'h2);
        chk("hold_err", 32'(err), 32'd0);
        plot_done = 1'b1;
        cyc();
        plot_done = 1'b0;
        wait_start("hold_next", 4'b0100);
`endif

        for (int i = 0; i < 3000; i++) begin
            req        = 4'($urandom);
            frame_tick = ($urandom % 8) == 0;
            plot_done  = ($urandom % 4) == 0;
            resetn     = ($urandom % 128) != 0;
            cyc();
        end
        resetn     = 1'b1;
        frame_tick = 1'b0;
        plot_done  = 1'b0;
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
